// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit.
// The state encoding is fixed and is also used by the output-decode stage.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 3;

    // Control states; all 8 encodings are used, so no illegal state exists
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 3'b000,
        DECODE   = 3'b001,
        WAIT_IN  = 3'b010,
        EXEC_IN  = 3'b011,
        EXEC_OUT = 3'b100,
        EXEC_DEC = 3'b101,
        EXEC_JNZ = 3'b110,
        HALT     = 3'b111
    } state_e;

    // Opcodes carried in IR[7:5]; 000/001/010 are NOPs
    localparam logic [OP_W-1:0] OP_IN   = 3'b011;
    localparam logic [OP_W-1:0] OP_OUT  = 3'b100;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b101;
    localparam logic [OP_W-1:0] OP_JNZ  = 3'b110;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

endpackage

// File: rtl/btn_sync_edge.sv
// Pushbutton synchroniser plus rising-edge detector.
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   btn_in    - raw asynchronous button, active-high
//   pulse_out - registered one-cycle pulse per rising edge of btn_in
// A held button yields exactly one pulse. SYNC_STAGES must be at least 2.
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift chain, previous-value flop and registered edge pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
            prev_q  <= sync_out;
            pulse_q <= sync_out & ~prev_q;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/control_fsm.sv
// Control unit state register and next-state logic for the accumulator CPU.
// Ports:
//   clk           - system clock
//   rst_n         - synchronous active-low reset
//   ir_opcode     - IR[7:5], valid from the cycle after FETCH
//   enter         - raw asynchronous Enter pushbutton, active-high
//   current_state - registered state to the output-decode stage
//   waiting_input - high while in WAIT_IN
//   halted        - high while in HALT
//   instr_count   - saturating count of DECODE cycles
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    ir_opcode,
    input  logic               enter,
    output logic [STATE_W-1:0] current_state,
    output logic               waiting_input,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting_q, halted_q;
    logic             enter_pulse;

    // Enter edge pulse; only consumed while sitting in WAIT_IN
    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_enter_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (enter),
        .pulse_out(enter_pulse)
    );

    // State, counter and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            waiting_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Status flags track the next state so they line up with state_q
            waiting_q <= (state_d == WAIT_IN);
            halted_q  <= (state_d == HALT);
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                case (ir_opcode)
                    OP_IN:   state_d = WAIT_IN;
                    OP_OUT:  state_d = EXEC_OUT;
                    OP_DEC:  state_d = EXEC_DEC;
                    OP_JNZ:  state_d = EXEC_JNZ;
                    OP_HALT: state_d = HALT;
                    default: state_d = FETCH;
                endcase
            end
            WAIT_IN:  if (enter_pulse) state_d = EXEC_IN;
            EXEC_IN:  state_d = FETCH;
            EXEC_OUT: state_d = FETCH;
            EXEC_DEC: state_d = FETCH;
            EXEC_JNZ: state_d = FETCH;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    assign current_state = STATE_W'(state_q);
    assign waiting_input = waiting_q;
    assign halted        = halted_q;
    assign instr_count   = cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import cpu_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [2:0]       state;
        logic             waiting;
        logic             halted;
        logic [CNT_W-1:0] count;
    } obs_t;

    logic             clk;
    logic             rst_n;
    logic [2:0]       ir_opcode;
    logic             enter;
    logic [2:0]       current_state;
    logic             waiting_input;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    control_fsm #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_opcode    (ir_opcode),
        .enter        (enter),
        .current_state(current_state),
        .waiting_input(waiting_input),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t             exp_q[$];
    logic [CNT_W-1:0] m_cnt;
    state_e           m_last;
    int               checks;
    int               passed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard model: counter advances on the edge that leaves DECODE
    task automatic push_exp(input state_e s);
        obs_t e;
        if (m_last == DECODE && m_cnt != CNT_MAX) m_cnt = m_cnt + CNT_W'(1);
        e.state   = 3'(s);
        e.waiting = (s == WAIT_IN);
        e.halted  = (s == HALT);
        e.count   = m_cnt;
        exp_q.push_back(e);
        m_last = s;
    endtask

    task automatic push_reset();
        obs_t e;
        m_cnt     = '0;
        m_last    = FETCH;
        e.state   = 3'(FETCH);
        e.waiting = 1'b0;
        e.halted  = 1'b0;
        e.count   = '0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_cnt  = '0;
        m_last = FETCH;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b0; enter = 1'b0; ir_opcode = 3'b100;
        for (int i = 0; i < 2; i++) begin
            push_reset();
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL reset[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_out_seq();
        obs_t e, o;
        state_e seq [6] = '{DECODE, EXEC_OUT, FETCH, DECODE, EXEC_OUT, FETCH};
        ir_opcode = 3'b100;
        for (int i = 0; i < 6; i++) begin
            push_exp(seq[i]);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL out_seq[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
    endtask

    task automatic test_wait_in();
        obs_t e, o;
        state_e s;
        do_reset();
        ir_opcode = 3'b011; enter = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (i == 22) enter = 1'b1;
            if (i == 72) enter = 1'b0;
            if (i == 0)       s = DECODE;
            else if (i < 25)  s = WAIT_IN;
            else if (i == 25) s = EXEC_IN;
            else if (i == 26) s = FETCH;
            else if (i == 27) s = DECODE;
            else              s = WAIT_IN;
            push_exp(s);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL wait_in[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
    endtask

    task automatic test_enter_early();
        obs_t e, o;
        state_e s;
        do_reset();
        ir_opcode = 3'b000; enter = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) begin ir_opcode = 3'b011; enter = 1'b0; end
            if (i == 15) enter = 1'b1;
            if (i == 19) enter = 1'b0;
            if (i == 0)       s = DECODE;
            else if (i == 1)  s = FETCH;
            else if (i == 2)  s = DECODE;
            else if (i < 18)  s = WAIT_IN;
            else if (i == 18) s = EXEC_IN;
            else if (i == 19) s = FETCH;
            else if (i == 20) s = DECODE;
            else              s = WAIT_IN;
            push_exp(s);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL enter_early[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
    endtask

    task automatic test_halt();
        obs_t e, o;
        do_reset();
        ir_opcode = 3'b111; enter = 1'b0;
        for (int i = 0; i < 102; i++) begin
            push_exp((i == 0) ? DECODE : HALT);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL halt[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
        rst_n = 1'b0;
        push_reset();
        tick();
        rst_n = 1'b1;
        e = exp_q.pop_front();
        o = {current_state, waiting_input, halted, instr_count};
        checks++;
        if (o !== e)
            $display("FAIL halt_reset: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                     o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
        else passed++;
    endtask

    task automatic test_nop_saturate();
        obs_t e, o;
        do_reset();
        ir_opcode = 3'b000; enter = 1'b0;
        for (int i = 0; i < 40; i++) begin
            push_exp((i % 2 == 0) ? DECODE : FETCH);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL nop_sat[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
    endtask

    task automatic test_reset_in_wait();
        obs_t e, o;
        do_reset();
        ir_opcode = 3'b011; enter = 1'b0;
        // Enter rises so its pulse is live exactly when reset is applied
        for (int i = 0; i < 6; i++) begin
            if (i == 3) enter = 1'b1;
            push_exp((i == 0) ? DECODE : WAIT_IN);
            tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL rst_wait_pre[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
        rst_n = 1'b0; enter = 1'b0;
        push_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) push_exp((i == 1) ? DECODE : WAIT_IN);
            if (i > 0) tick();
            e = exp_q.pop_front();
            o = {current_state, waiting_input, halted, instr_count};
            checks++;
            if (o !== e)
                $display("FAIL rst_wait_post[%0d]: got st=%b w=%b h=%b cnt=%0d, want st=%b w=%b h=%b cnt=%0d",
                         i, o.state, o.waiting, o.halted, o.count, e.state, e.waiting, e.halted, e.count);
            else passed++;
        end
    endtask

    initial begin
        checks = 0; passed = 0;
        m_cnt = '0; m_last = FETCH;
        rst_n = 1'b0; enter = 1'b0; ir_opcode = 3'b000;
        test_reset();
        test_out_seq();
        test_wait_in();
        test_enter_early();
        test_halt();
        test_nop_saturate();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
